serial_frame_rx: RTL and testbench
==================================

Name: serial_frame_rx

Overview:
Byte-stream frame decoder. It sits between the UART byte receiver and the data multiplexer stage. It parses fixed 5-byte command frames: header, selector, data high, data low, checksum. On a valid frame it presents selector and a 16-bit data word, then raises a data_lock strobe for the downstream mux, which latches on the strobe's rising edge. Malformed or stalled frames are dropped and counted.

Parameters:
HEADER, 8'hA5, frame start byte.
TIMEOUT_CYCLES, 16'd5000, maximum consecutive clk cycles without rx_valid inside a frame (legal 2..65535).
LOCK_WIDTH, 2, number of cycles data_lock stays high per accepted frame (legal 1..4).

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
rx_data  in  8  received byte from UART
rx_valid  in  1  one-cycle qualifier for rx_data
selector  out  8  selector from last accepted frame
data_word  out  16  {data_hi, data_lo} from last accepted frame
data_lock  out  1  strobe, high LOCK_WIDTH cycles per accepted frame
frame_err  out  1  one-cycle pulse on checksum error or timeout
err_count  out  8  saturating count of frame_err events

Behaviour:
- Reset (reset==0 at a clk edge): FSM to IDLE; selector, data_word, err_count = 0; data_lock, frame_err = 0; shadow regs, timeout and lock counters = 0. Reset mid-frame discards the partial frame. Reset overrides all other activity.
- FSM states: IDLE, SEL, DHI, DLO, CHK. A state advances only on a cycle with rx_valid=1.
  - IDLE: rx_data==HEADER goes to SEL. Any other byte is ignored and raises no error.
  - SEL: store shadow_sel, go to DHI.
  - DHI: store shadow_hi, go to DLO.
  - DLO: store shadow_lo, go to CHK.
  - CHK: always returns to IDLE.
- A HEADER value received in SEL, DHI, DLO or CHK is ordinary payload. There is no resync.
- Checksum: expected = (shadow_sel + shadow_hi + shadow_lo) mod 256, 8-bit wrap, carries discarded.
- Match in CHK: on the same clk edge that samples the checksum byte, selector <= shadow_sel, data_word <= {shadow_hi, shadow_lo}, data_lock <= 1.
  - data_lock stays high exactly LOCK_WIDTH cycles, then drops to 0.
  - selector and data_word are stable whenever data_lock is high.
- Mismatch in CHK: selector, data_word and data_lock unchanged. frame_err pulses high for one cycle on that edge. err_count increments.
- Timeout: the counter clears on every rx_valid and while in IDLE. In SEL..CHK it increments on each cycle without rx_valid. When TIMEOUT_CYCLES consecutive idle cycles are reached: FSM to IDLE, frame_err pulses for one cycle, err_count increments. rx_valid on the same cycle as expiry wins, so no timeout occurs.
- err_count saturates at 255 and never wraps.
- Overlap: LOCK_WIDTH ≤ 4 and a frame needs ≥5 rx_valid cycles, so a new acceptance cannot occur while data_lock is high. This keeps a distinct rising edge per frame.
- rx_valid while data_lock is high is processed normally.
- Latency: 0 cycles from the checksum byte edge to selector, data_word and data_lock update. All outputs are registered.

Test Plan:
1. Good frame: A5 01 12 34 47, one byte per cycle. Required: selector=01 and data_word=1234 on the checksum edge; data_lock high exactly 2 cycles; frame_err never set; err_count=0.
2. Bad checksum: after test 1, send A5 00 AB CD 00. Required: one frame_err pulse; err_count=1; selector=01 and data_word=1234 unchanged; data_lock stays 0.
3. Timeout: send A5 01, then no rx_valid. Required: frame_err pulse exactly 5000 cycles after byte 01; err_count increments. Then A5 02 00 10 12 is accepted: selector=02, data_word=0010.
4. Leading garbage and wrap: send 00 FF 5A, then A5 FF FF 02 00 (sum 0x200 wraps to 00). Required: the garbage bytes raise no error; frame accepted with selector=FF, data_word=FF02.
5. Reset mid-frame: send A5 01 12, then reset=0 for 1 cycle, then 34 47. Required: all outputs 0 after reset; trailing bytes ignored; no data_lock, no frame_err.
6. Saturation: send 260 bad-checksum frames. Required: 260 frame_err pulses; err_count holds 255.

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: parses 5-byte header/selector/data/checksum frames into a locked selector/data word
module serial_frame_rx #(
   parameter logic [7:0]  HEADER         = 8'hA5,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd5000,
   parameter int          LOCK_WIDTH     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  selector,
   output logic [15:0] data_word,
   output logic        data_lock,
   output logic        frame_err,
   output logic [7:0]  err_count
);
   typedef enum logic [2:0] {IDLE, SEL, DHI, DLO, CHK} state_t;
   localparam logic [15:0] T_LAST = TIMEOUT_CYCLES - 16'd1;
   state_t      state;
   logic [7:0]  shadow_sel, shadow_hi, shadow_lo, sum;
   logic [15:0] tcnt;
   logic [2:0]  lcnt;
   logic        expire, accept, bad;
   assign sum    = shadow_sel + shadow_hi + shadow_lo;
   assign expire = state != IDLE && !rx_valid && tcnt == T_LAST;
   assign accept = state == CHK && rx_valid && rx_data == sum;
   assign bad    = expire || (state == CHK && rx_valid && rx_data != sum);
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         shadow_sel <= '0;
         shadow_hi  <= '0;
         shadow_lo  <= '0;
         tcnt       <= '0;
         lcnt       <= '0;
         selector   <= '0;
         data_word  <= '0;
         data_lock  <= 1'b0;
         frame_err  <= 1'b0;
         err_count  <= '0;
      end else begin
         frame_err <= bad;
         if (bad) err_count <= err_count + 8'(err_count != 8'hFF);
         tcnt <= (state == IDLE || rx_valid || expire) ? '0 : tcnt + 16'd1;
         // lcnt holds the remaining high cycles after the first one
         if (accept) begin
            selector  <= shadow_sel;
            data_word <= {shadow_hi, shadow_lo};
            data_lock <= 1'b1;
            lcnt      <= 3'(LOCK_WIDTH - 1);
         end else if (lcnt != 3'd0) lcnt <= lcnt - 3'd1;
         else data_lock <= 1'b0;
         if (expire) state <= IDLE;
         else if (rx_valid)
            case (state)
               IDLE:    state <= rx_data == HEADER ? SEL : IDLE;
               SEL:     begin shadow_sel <= rx_data; state <= DHI; end
               DHI:     begin shadow_hi <= rx_data; state <= DLO; end
               DLO:     begin shadow_lo <= rx_data; state <= CHK; end
               default: state <= IDLE;
            endcase
      end
   end
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed frame sequences with hand-computed expectations for serial_frame_rx
module tb_serial_frame_rx;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic [7:0]  selector;
   logic [15:0] data_word;
   logic        data_lock;
   logic        frame_err;
   logic [7:0]  err_count;
   int passed = 0, total = 0, lock_n = 0, ferr_n = 0, l0, f0;

   serial_frame_rx dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .selector(selector), .data_word(data_word), .data_lock(data_lock),
      .frame_err(frame_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (data_lock) lock_n++;
      if (frame_err) ferr_n++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [7:0] b);
      rx_data = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   initial begin
      repeat (3) tick();
      reset = 1'b1;
      tick();
      chk("rst_selector", 32'(selector), 32'h0);
      chk("rst_data_word", 32'(data_word), 32'h0);
      chk("rst_lock", 32'(data_lock), 32'h0);
      chk("rst_ferr", 32'(frame_err), 32'h0);
      chk("rst_errcnt", 32'(err_count), 32'h0);
      // good frame
      l0 = lock_n; f0 = ferr_n;
      put(8'hA5); put(8'h01); put(8'h12); put(8'h34);
      chk("t1_lock_before", 32'(data_lock), 32'h0);
      put(8'h47);
      chk("t1_selector", 32'(selector), 32'h01);
      chk("t1_data_word", 32'(data_word), 32'h1234);
      chk("t1_lock_edge", 32'(data_lock), 32'h1);
      tick();
      chk("t1_lock_2nd", 32'(data_lock), 32'h1);
      tick();
      chk("t1_lock_drop", 32'(data_lock), 32'h0);
      repeat (3) tick();
      chk("t1_lock_cycles", 32'(lock_n - l0), 32'd2);
      chk("t1_no_ferr", 32'(ferr_n - f0), 32'd0);
      chk("t1_errcnt", 32'(err_count), 32'h0);
      // bad checksum
      l0 = lock_n; f0 = ferr_n;
      put(8'hA5); put(8'h00); put(8'hAB); put(8'hCD); put(8'h00);
      chk("t2_ferr", 32'(frame_err), 32'h1);
      chk("t2_errcnt", 32'(err_count), 32'h1);
      tick();
      chk("t2_ferr_pulse", 32'(frame_err), 32'h0);
      chk("t2_selector", 32'(selector), 32'h01);
      chk("t2_data_word", 32'(data_word), 32'h1234);
      chk("t2_no_lock", 32'(lock_n - l0), 32'd0);
      chk("t2_ferr_count", 32'(ferr_n - f0), 32'd1);
      // timeout
      put(8'hA5); put(8'h01);
      repeat (4999) tick();
      chk("t3_no_early_timeout", 32'(frame_err), 32'h0);
      tick();
      chk("t3_timeout_ferr", 32'(frame_err), 32'h1);
      chk("t3_errcnt", 32'(err_count), 32'h2);
      tick();
      put(8'hA5); put(8'h02); put(8'h00); put(8'h10); put(8'h12);
      chk("t3_selector", 32'(selector), 32'h02);
      chk("t3_data_word", 32'(data_word), 32'h0010);
      chk("t3_lock", 32'(data_lock), 32'h1);
      repeat (3) tick();
      // garbage then checksum wrap
      f0 = ferr_n;
      put(8'h00); put(8'hFF); put(8'h5A);
      tick();
      chk("t4_garbage_errcnt", 32'(err_count), 32'h2);
      put(8'hA5); put(8'hFF); put(8'hFF); put(8'h02); put(8'h00);
      chk("t4_selector", 32'(selector), 32'hFF);
      chk("t4_data_word", 32'(data_word), 32'hFF02);
      chk("t4_lock", 32'(data_lock), 32'h1);
      chk("t4_no_ferr", 32'(ferr_n - f0), 32'd0);
      repeat (3) tick();
      // reset mid-frame
      put(8'hA5); put(8'h01); put(8'h12);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("t5_selector", 32'(selector), 32'h0);
      chk("t5_data_word", 32'(data_word), 32'h0);
      chk("t5_errcnt", 32'(err_count), 32'h0);
      l0 = lock_n; f0 = ferr_n;
      put(8'h34); put(8'h47);
      repeat (4) tick();
      chk("t5_no_lock", 32'(lock_n - l0), 32'd0);
      chk("t5_no_ferr", 32'(ferr_n - f0), 32'd0);
      chk("t5_selector_after", 32'(selector), 32'h0);
      // saturation
      f0 = ferr_n;
      for (int i = 0; i < 260; i++) begin
         put(8'hA5); put(8'h00); put(8'hAB); put(8'hCD); put(8'h00);
         if (i == 253) chk("t6_errcnt_254", 32'(err_count), 32'd254);
      end
      tick();
      chk("t6_ferr_pulses", 32'(ferr_n - f0), 32'd260);
      chk("t6_errcnt_sat", 32'(err_count), 32'd255);
      chk("t6_selector", 32'(selector), 32'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
